// File: rtl/asrv32_clint_pkg.sv
// Shared register map, reset constants and helpers for the asrv32 core-local interruptor.
package asrv32_clint_pkg;

  localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
  localparam logic [31:0] MTIME_LO      = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI      = 32'h0000_BFFC;
  localparam logic [63:0] MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } reg_sel_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wmask);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/asrv32_clint_hart.sv
// Per-hart CLINT channel: msip bit, 64-bit mtimecmp, registered timer compare
// and external IRQ synchroniser.
module asrv32_clint_hart
  import asrv32_clint_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msip_we,
  input  logic        cmp_lo_we,
  input  logic        cmp_hi_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic [63:0] mtime,
  input  logic        ext_irq_async,
  output logic        msip,
  output logic [63:0] mtimecmp,
  output logic        timer_irq,
  output logic        sw_irq,
  output logic        ext_irq
);

  localparam int STAGES = (SYNC_STAGES > 1) ? SYNC_STAGES : 1;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      msip      <= 1'b0;
      mtimecmp  <= MTIMECMP_RST;
      timer_irq <= 1'b0;
      sw_irq    <= 1'b0;
    end else begin
      if (msip_we && wmask[0]) msip <= wdata[0];
      if (cmp_lo_we) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wdata, wmask);
      if (cmp_hi_we) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, wmask);
      // Compare uses this cycle's registered values, so the level lags by one cycle.
      timer_irq <= (mtime >= mtimecmp);
      sw_irq    <= msip;
    end
  end

  // A zero-stage request still gets one flop so the output is always registered.
  if (STAGES == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= ext_irq_async;
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], ext_irq_async};
    end
  end

  assign ext_irq = sync_q[STAGES-1];

endmodule

// File: rtl/asrv32_clint.sv
// Core-local interruptor top: prescaled 64-bit mtime, bus decode/read mux and
// one asrv32_clint_hart channel per hart.
module asrv32_clint
  import asrv32_clint_pkg::*;
#(
  parameter int NUM_HARTS   = 1,
  parameter int TICK_DIV    = 100,
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wmask,
  output logic                 o_ack,
  output logic [31:0]          o_rdata,
  input  logic                 i_mtime_wr,
  input  logic [63:0]          i_mtime_din,
  input  logic [NUM_HARTS-1:0] i_ext_irq,
  output logic [NUM_HARTS-1:0] o_timer_irq,
  output logic [NUM_HARTS-1:0] o_sw_irq,
  output logic [NUM_HARTS-1:0] o_ext_irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_nxt;
  logic [63:0]   mtime_q, mtime_nxt;
  logic [31:0]   addr;
  logic [31:0]   rdata_nxt;
  logic [2:0]    hart;
  logic [HW-1:0] hart_idx;
  logic          bus_wr;
  reg_sel_e      sel;

  logic [NUM_HARTS-1:0] msip_v;
  logic [63:0]          cmp_v [NUM_HARTS];

  assign addr     = 32'(i_addr);
  assign hart_idx = HW'(hart);
  assign bus_wr   = i_req & i_wr;

  // Misaligned addresses and hart slots beyond NUM_HARTS decode as unmapped.
  always_comb begin
    sel  = SEL_NONE;
    hart = '0;
    if (addr[31:2] == MTIME_LO[31:2]) begin
      sel = SEL_MTIME_LO;
    end else if (addr[31:2] == MTIME_HI[31:2]) begin
      sel = SEL_MTIME_HI;
    end else if (addr[31:5] == MSIP_BASE[31:5]) begin
      sel  = SEL_MSIP;
      hart = addr[4:2];
    end else if (addr[31:6] == MTIMECMP_BASE[31:6]) begin
      sel  = addr[2] ? SEL_CMP_HI : SEL_CMP_LO;
      hart = addr[5:3];
    end
    if (addr[1:0] != 2'b00 || int'(hart) >= NUM_HARTS) sel = SEL_NONE;
  end

  // Priority: direct load, then bus write, then prescaler tick.
  always_comb begin
    presc_nxt = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    mtime_nxt = (presc_q == PRESC_MAX) ? mtime_q + 64'd1 : mtime_q;
    if (i_mtime_wr) begin
      mtime_nxt = i_mtime_din;
      presc_nxt = '0;
    end else if (bus_wr && sel == SEL_MTIME_LO) begin
      mtime_nxt = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wdata, i_wmask)};
      presc_nxt = '0;
    end else if (bus_wr && sel == SEL_MTIME_HI) begin
      mtime_nxt = {merge_bytes(mtime_q[63:32], i_wdata, i_wmask), mtime_q[31:0]};
      presc_nxt = '0;
    end
  end

  // mtime reads return the post-tick value so software sees the edge's result.
  always_comb begin
    rdata_nxt = '0;
    case (sel)
      SEL_MSIP:     rdata_nxt = {31'd0, msip_v[hart_idx]};
      SEL_CMP_LO:   rdata_nxt = cmp_v[hart_idx][31:0];
      SEL_CMP_HI:   rdata_nxt = cmp_v[hart_idx][63:32];
      SEL_MTIME_LO: rdata_nxt = mtime_nxt[31:0];
      SEL_MTIME_HI: rdata_nxt = mtime_nxt[63:32];
      default:      rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      o_ack   <= 1'b0;
      o_rdata <= '0;
    end else begin
      presc_q <= presc_nxt;
      mtime_q <= mtime_nxt;
      o_ack   <= i_req;
      o_rdata <= (i_req && !i_wr) ? rdata_nxt : '0;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic hit;
    assign hit = bus_wr && (int'(hart) == h);

    asrv32_clint_hart #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_hart (
      .clk           (clk),
      .rst           (rst),
      .msip_we       (hit && sel == SEL_MSIP),
      .cmp_lo_we     (hit && sel == SEL_CMP_LO),
      .cmp_hi_we     (hit && sel == SEL_CMP_HI),
      .wdata         (i_wdata),
      .wmask         (i_wmask),
      .mtime         (mtime_q),
      .ext_irq_async (i_ext_irq[h]),
      .msip          (msip_v[h]),
      .mtimecmp      (cmp_v[h]),
      .timer_irq     (o_timer_irq[h]),
      .sw_irq        (o_sw_irq[h]),
      .ext_irq       (o_ext_irq[h])
    );
  end

endmodule
